// File: rtl/reset_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the PLL lock / reset sequencer.
// The top derives its counter width and parameter legality check from here.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter is shared by all phases, so it must hold the largest terminal count.
    function automatic int counter_width(input int lock_filter, input int hold_cycles,
                                         input int release_span);
        int span;
        span = max3(lock_filter, hold_cycles, release_span);
        return (span < 1) ? 1 : $clog2(span + 1);
    endfunction

    function automatic bit params_legal(input int num_channels, input int lock_filter,
                                        input int hold_cycles, input int stagger_cycles,
                                        input int loss_cnt_w);
        return (num_channels >= 1) && (lock_filter >= 1) && (hold_cycles >= 1) &&
               (stagger_cycles >= 0) && (loss_cnt_w >= 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser with a synchronous active-low clear.
// Reusable for any single-clock crossing of slow-changing level signals.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= data;
            synced <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Clock-lock filter and staggered reset release for downstream reset domains.
// Re-enters reset on PLL lock loss or a software request and counts lock losses.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS   = 3,
    parameter int LOCK_FILTER    = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 2,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                    clock_clock,
    input  logic                    resetN,
    input  logic                    pll_lock,
    input  logic                    sw_reset_req,
    output logic [NUM_CHANNELS-1:0] rst_out,
    output logic                    ready,
    output logic [LOSS_CNT_W-1:0]   lock_loss_cnt
);

    localparam int RELEASE_SPAN = (NUM_CHANNELS - 1) * STAGGER_CYCLES;
    localparam int CNT_W        = counter_width(LOCK_FILTER, HOLD_CYCLES, RELEASE_SPAN);

    localparam logic [CNT_W-1:0]      FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      RELEASE_LAST = CNT_W'(RELEASE_SPAN);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX     = '1;

    if (!params_legal(NUM_CHANNELS, LOCK_FILTER, HOLD_CYCLES, STAGGER_CYCLES, LOSS_CNT_W))
    begin : g_illegal_params
        $error("reset_sequencer: NUM_CHANNELS, LOCK_FILTER, HOLD_CYCLES, LOSS_CNT_W must be >= 1");
    end

    seq_state_t              state;
    seq_state_t              state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [CNT_W-1:0]        stagger_pos;
    logic [NUM_CHANNELS-1:0] release_rst;
    logic [NUM_CHANNELS-1:0] rst_next;
    logic                    ready_next;
    logic                    loss_event;
    logic                    lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) lock_sync (
        .clock  (clock_clock),
        .clear_n(resetN),
        .data   (pll_lock),
        .synced (lock_s)
    );

    // cnt holds the stagger position of the previous edge, so this edge sits one further on.
    always_comb begin
        release_rst = '1;
        stagger_pos = (state == RELEASE) ? cnt + CNT_W'(1) : '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            release_rst[i] = (stagger_pos < CNT_W'(i * STAGGER_CYCLES));
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rst_next   = rst_out;
        loss_event = 1'b0;

        if ((state != WAIT_LOCK) && !lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
            rst_next   = '1;
            loss_event = 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_next = '1;
                    if (!lock_s) begin
                        cnt_next = '0;
                    end else if (cnt == FILTER_LAST) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    rst_next = '1;
                    if (cnt == HOLD_LAST) begin
                        cnt_next = '0;
                        rst_next = release_rst;
                        if (RELEASE_SPAN == 0) begin
                            state_next = RUN;
                        end else begin
                            state_next = RELEASE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    cnt_next = stagger_pos;
                    rst_next = release_rst;
                    if (stagger_pos == RELEASE_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    rst_next = '0;
                    if (sw_reset_req) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        rst_next   = '1;
                    end
                end
                default: begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                    rst_next   = '1;
                end
            endcase
        end

        ready_next = (state_next == RUN);
    end

    always_ff @(posedge clock_clock) begin
        if (!resetN) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            rst_out       <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rst_out <= rst_next;
            ready   <= ready_next;
            if (loss_event && (lock_loss_cnt != LOSS_MAX)) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timeline table, corner sequences,
// and randomized traffic compared against a timestamp-based reference model.
module tb_reset_sequencer;

    localparam int NCH     = 3;
    localparam int LF      = 4;
    localparam int HOLDC   = 8;
    localparam int STAG    = 2;
    localparam int LW      = 8;
    localparam int LOSSMAX = (1 << LW) - 1;

    logic            clock = 1'b0;
    logic            resetN;
    logic            pll_lock;
    logic            sw_reset_req;
    logic [NCH-1:0]  rst_out;
    logic            ready;
    logic [LW-1:0]   lock_loss_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .NUM_CHANNELS  (NCH),
        .LOCK_FILTER   (LF),
        .HOLD_CYCLES   (HOLDC),
        .STAGGER_CYCLES(STAG),
        .LOSS_CNT_W    (LW)
    ) dut (
        .clock_clock  (clock),
        .resetN       (resetN),
        .pll_lock     (pll_lock),
        .sw_reset_req (sw_reset_req),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    typedef struct {
        string          name;
        int             cycles;
        logic           pll;
        logic           sw;
        logic           rstn;
        logic [NCH-1:0] exp_rst;
        logic           exp_ready;
        logic [LW-1:0]  exp_loss;
    } vec_t;

    vec_t vecs[$];

    // Reference model: tracks when HOLD began and derives each release from elapsed edges.
    int             m_edge = 0;
    int             m_hold_start = 0;
    int             m_filt = 0;
    int             m_loss = 0;
    bit             m_seq = 1'b0;
    bit             m_s1 = 1'b0;
    bit             m_s2 = 1'b0;
    bit             m_valid = 1'b0;
    bit             m_ls;
    int             m_k;
    logic [NCH-1:0] m_rst = '1;
    logic           m_ready = 1'b0;

    always @(posedge clock) begin
        if (!resetN) begin
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_seq   = 1'b0;
            m_filt  = 0;
            m_loss  = 0;
            m_valid = 1'b1;
        end else begin
            m_ls = m_s2;
            if (m_seq && !m_ls) begin
                m_seq  = 1'b0;
                m_filt = 0;
                if (m_loss < LOSSMAX) m_loss = m_loss + 1;
            end else if (m_seq) begin
                if (sw_reset_req && m_ready) m_hold_start = m_edge;
            end else if (m_ls) begin
                m_filt = m_filt + 1;
                if (m_filt == LF) begin
                    m_seq        = 1'b1;
                    m_hold_start = m_edge;
                    m_filt       = 0;
                end
            end else begin
                m_filt = 0;
            end
            m_s2 = m_s1;
            m_s1 = pll_lock;
        end
        m_rst   = '1;
        m_ready = 1'b0;
        if (m_seq) begin
            m_k = m_edge - m_hold_start;
            for (int i = 0; i < NCH; i++) begin
                if (m_k >= HOLDC + i * STAG) m_rst[i] = 1'b0;
            end
            m_ready = (m_k >= HOLDC + (NCH - 1) * STAG);
        end
        m_edge = m_edge + 1;
    end

    task automatic checkOutput(input string name, input logic [NCH-1:0] exp_rst,
                               input logic exp_ready, input logic [LW-1:0] exp_loss);
        compared++;
        if (rst_out !== exp_rst || ready !== exp_ready || lock_loss_cnt !== exp_loss) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got rst_out=%b ready=%b loss=%0d, expected rst_out=%b ready=%b loss=%0d",
                     name, $time, rst_out, ready, lock_loss_cnt, exp_rst, exp_ready, exp_loss);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) checkOutput("model", m_rst, m_ready, LW'(m_loss));
    end

    task automatic applyStimulus(input logic pll, input logic sw, input logic rstn);
        pll_lock     = pll;
        sw_reset_req = sw;
        resetN       = rstn;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic runCycles(input int n, input logic pll, input logic sw, input logic rstn);
        for (int c = 0; c < n; c++) applyStimulus(pll, sw, rstn);
    endtask

    function automatic void addVec(input string name, input int cycles, input logic pll,
                                   input logic sw, input logic rstn, input logic [NCH-1:0] er,
                                   input logic erdy, input logic [LW-1:0] el);
        vec_t v;
        v.name = name; v.cycles = cycles; v.pll = pll; v.sw = sw; v.rstn = rstn;
        v.exp_rst = er; v.exp_ready = erdy; v.exp_loss = el;
        vecs.push_back(v);
    endfunction

    initial begin
        pll_lock     = 1'b0;
        sw_reset_req = 1'b0;
        resetN       = 1'b0;

        // Clean power-up (edge 0 = first edge with lock high), then a lock drop at edge 30.
        addVec("reset_state",   3, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0);
        addVec("pre_release",  13, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0);
        addVec("ch0_release",   1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0);
        addVec("ch0_only",      1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0);
        addVec("ch1_release",   1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 8'd0);
        addVec("ch1_only",      1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 8'd0);
        addVec("all_released",  1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0);
        addVec("run_steady",   12, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0);
        addVec("loss_drop",     1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0);
        addVec("loss_pipe",     1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0);
        addVec("loss_hit",      1, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd1);
        addVec("reseq_hold",   11, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd1);
        addVec("reseq_ch0",     1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd1);
        addVec("reseq_ready",   4, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 8'd1);
        // Filter glitch: one low at edge 2 pushes release from edge 13 to edge 16.
        addVec("glitch_reset",  3, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0);
        addVec("glitch_pre",    2, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0);
        addVec("glitch_low",    1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0);
        addVec("glitch_late",  13, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0);
        addVec("glitch_ch0",    1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0);
        addVec("glitch_ready",  4, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0);

        foreach (vecs[j]) begin
            runCycles(vecs[j].cycles, vecs[j].pll, vecs[j].sw, vecs[j].rstn);
            checkOutput(vecs[j].name, vecs[j].exp_rst, vecs[j].exp_ready, vecs[j].exp_loss);
        end

        // Software reset at edge 40, ignored second pulse at edge 43 while in HOLD.
        runCycles(3, 1'b0, 1'b0, 1'b0);
        runCycles(40, 1'b1, 1'b0, 1'b1);
        checkOutput("sw_pre_run", 3'b000, 1'b1, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("sw_assert", 3'b111, 1'b0, 8'd0);
        runCycles(2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(4, 1'b1, 1'b0, 1'b1);
        checkOutput("sw_hold", 3'b111, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("sw_ch0", 3'b110, 1'b0, 8'd0);
        runCycles(4, 1'b1, 1'b0, 1'b1);
        checkOutput("sw_run_again", 3'b000, 1'b1, 8'd0);

        // Lock loss and software request land on the same RUN edge; lock loss wins.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("simul_loss", 3'b111, 1'b0, 8'd1);
        runCycles(11, 1'b1, 1'b0, 1'b1);
        checkOutput("simul_wait", 3'b111, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("simul_ch0", 3'b110, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset_mid_release", 3'b111, 1'b0, 8'd0);

        // Saturation: each 8-edge loop costs exactly one loss (in RUN first, then in HOLD).
        runCycles(2, 1'b0, 1'b0, 1'b0);
        runCycles(18, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            runCycles(7, 1'b1, 1'b0, 1'b1);
            if (n == 253) checkOutput("sat_254", 3'b111, 1'b0, 8'd254);
            if (n == 254) checkOutput("sat_255", 3'b111, 1'b0, 8'd255);
        end
        checkOutput("sat_hold", 3'b111, 1'b0, 8'd255);

        // Randomized traffic; the model comparison runs on every falling edge.
        for (int seg = 0; seg < 15; seg++) begin
            int low_range;
            low_range = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 15 : 63);
            for (int c = 0; c < 200; c++) begin
                applyStimulus($urandom_range(0, low_range) != 0,
                              $urandom_range(0, 5) == 0,
                              $urandom_range(0, 299) != 0);
            end
        end

        @(posedge clock);
        #1;
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
